// File: rtl/osecpu_dr_uart_tx.sv
// Debug UART for the OSECPU core: each new value of dr goes out as 8 hex digits plus CR LF, 8N1.
// One value can wait while a frame is in flight; overwritten waiting values are counted.
module osecpu_dr_uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dr,
  output logic        tx,
  output logic        busy,
  output logic [7:0]  dropped
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [3:0]       char_q, char_d;
  logic [31:0]      frame_q, frame_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [31:0]      pending_q, pending_d;
  logic             pending_valid_q, pending_valid_d;
  logic [7:0]       dropped_q, dropped_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;

  logic        capture;
  logic        cnt_done;
  logic [2:0]  bit_nxt;
  logic [31:0] frame_shifted;
  logic [3:0]  nibble;
  logic [7:0]  char_byte;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : 8'h37 + {4'h0, n};
  endfunction

  // Current character: indices 0..7 walk the nibbles MSB first, then CR and LF.
  always_comb begin
    frame_shifted = frame_q << {char_q[2:0], 2'b00};
    nibble        = frame_shifted[31:28];
    case (char_q)
      4'd8:    char_byte = 8'h0D;
      4'd9:    char_byte = 8'h0A;
      default: char_byte = hex_ascii(nibble);
    endcase
  end

  assign capture  = (dr != shadow_q);
  assign cnt_done = (cnt_q == CNT_MAX);
  assign bit_nxt  = bit_q + 3'd1;

  always_comb begin
    // NOTE: every signal written here takes its registered value first, so no path leaves it unassigned and no latch is inferred.
    state_d         = state_q;
    cnt_d           = cnt_q;
    bit_d           = bit_q;
    char_d          = char_q;
    frame_d         = frame_q;
    shadow_d        = shadow_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    dropped_d       = dropped_q;
    tx_d            = tx_q;
    busy_d          = busy_q;

    if (capture) shadow_d = dr;

    // While a frame is in flight a new value parks in pending; the latest one wins.
    if (capture && state_q != IDLE) begin
      pending_d       = dr;
      pending_valid_d = 1'b1;
      if (pending_valid_q && dropped_q != 8'hFF) dropped_d = dropped_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (capture) begin
          frame_d = dr;
          char_d  = 4'd0;
          cnt_d   = '0;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (cnt_done) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = DATA;
          tx_d    = char_byte[0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_done) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_nxt;
            tx_d  = char_byte[bit_nxt];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_done) begin
          cnt_d = '0;
          if (char_q != 4'd9) begin
            char_d  = char_q + 4'd1;
            state_d = START;
            tx_d    = 1'b0;
          end else if (capture || pending_valid_q) begin
            // A value arriving on the very last stop cycle is newer than pending.
            frame_d         = capture ? dr : pending_q;
            pending_valid_d = 1'b0;
            char_d          = 4'd0;
            state_d         = START;
            tx_d            = 1'b0;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state registers update with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      bit_q           <= 3'd0;
      char_q          <= 4'd0;
      frame_q         <= 32'd0;
      shadow_q        <= 32'd0;
      pending_q       <= 32'd0;
      pending_valid_q <= 1'b0;
      dropped_q       <= 8'd0;
      tx_q            <= 1'b1;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      bit_q           <= bit_d;
      char_q          <= char_d;
      frame_q         <= frame_d;
      shadow_q        <= shadow_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      dropped_q       <= dropped_d;
      tx_q            <= tx_d;
      busy_q          <= busy_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign dropped = dropped_q;

endmodule

// File: tb/tb_osecpu_dr_uart_tx.sv
// Bench for osecpu_dr_uart_tx: a frame-offset line model checked every cycle,
// plus a mid-bit UART decoder and literal expectations for the directed scenarios.
module tb_osecpu_dr_uart_tx;

  localparam int C4 = 4;
  localparam int C5 = 5;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] dr4   = 32'd0;
  logic [31:0] dr5   = 32'd0;
  logic        tx4, busy4, tx5, busy5;
  logic [7:0]  dropped4, dropped5;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  logic [7:0] dec_buf [0:19];

  always #5 clk = ~clk;

  osecpu_dr_uart_tx #(.CLKS_PER_BIT(C4)) dut4 (
    .clk(clk), .reset(reset), .dr(dr4), .tx(tx4), .busy(busy4), .dropped(dropped4)
  );

  osecpu_dr_uart_tx #(.CLKS_PER_BIT(C5)) dut5 (
    .clk(clk), .reset(reset), .dr(dr5), .tx(tx5), .busy(busy5), .dropped(dropped5)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] char_of(input logic [31:0] v, input int i);
    logic [3:0] n;
    if (i == 8) return 8'h0D;
    if (i == 9) return 8'h0A;
    n = v[31-4*i -: 4];
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  // Line level at a given cycle offset from the start of a frame.
  function automatic logic bitf(input logic [31:0] v, input int off, input int c);
    int ch, bp;
    logic [7:0] b;
    ch = off / (10 * c);
    bp = (off % (10 * c)) / c;
    b  = char_of(v, ch);
    if (bp == 0) return 1'b0;
    if (bp == 9) return 1'b1;
    return b[bp-1];
  endfunction

  // Model of dut4: which value is on the line, how far into its frame, and the waiting slot.
  bit          m_active = 1'b0;
  logic [31:0] m_val    = 32'd0;
  logic [31:0] m_shadow = 32'd0;
  logic [31:0] m_pend   = 32'd0;
  bit          m_pv     = 1'b0;
  int          m_off    = 0;
  int          m_drop   = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active <= 1'b0;
      m_val    <= 32'd0;
      m_shadow <= 32'd0;
      m_pend   <= 32'd0;
      m_pv     <= 1'b0;
      m_off    <= 0;
      m_drop   <= 0;
    end else begin : step
      bit          act, pv, cap;
      logic [31:0] val, pend;
      int          off, drop;
      act  = m_active;
      val  = m_val;
      pend = m_pend;
      pv   = m_pv;
      off  = m_off;
      drop = m_drop;
      cap  = (dr4 != m_shadow);
      if (act) begin
        off++;
        if (cap) begin
          if (pv && drop < 255) drop++;
          pend = dr4;
          pv   = 1'b1;
        end
        if (off == 100 * C4) begin
          if (pv) begin
            val = pend;
            pv  = 1'b0;
            off = 0;
          end else begin
            act = 1'b0;
          end
        end
      end else if (cap) begin
        act = 1'b1;
        val = dr4;
        off = 0;
      end
      m_active <= act;
      m_val    <= val;
      m_shadow <= dr4;
      m_pend   <= pend;
      m_pv     <= pv;
      m_off    <= off;
      m_drop   <= drop;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_tx", 32'(tx4), m_active ? 32'(bitf(m_val, m_off, C4)) : 32'd1);
      check("model_busy", 32'(busy4), 32'(m_active));
      check("model_dropped", 32'(dropped4), 32'(m_drop));
    end
  end

  // Mid-bit UART receiver on tx4; always called at a falling clock edge.
  task automatic decode4(input int n);
    for (int k = 0; k < n; k++) begin
      int budget;
      budget = 0;
      while (tx4 !== 1'b0 && budget < 3000) begin
        @(negedge clk);
        budget++;
      end
      check("start_found", 32'(tx4), 32'd0);
      if (tx4 !== 1'b0) return;
      repeat (C4 / 2) @(negedge clk);
      check("start_bit_mid", 32'(tx4), 32'd0);
      for (int j = 0; j < 8; j++) begin
        repeat (C4) @(negedge clk);
        dec_buf[k][j] = tx4;
      end
      repeat (C4) @(negedge clk);
      check("stop_bit", 32'(tx4), 32'd1);
    end
  endtask

  task automatic wait_idle(input int budget);
    int b;
    b = 0;
    while (busy4 !== 1'b0 && b < budget) begin
      @(negedge clk);
      b++;
    end
    check("idle_reached", 32'(busy4), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_a [0:9];
    logic [7:0] exp_ow [0:19];
    logic [7:0] exp_5 [0:9];
    int lowcnt;
    int busycnt;

    exp_a  = '{8'h31, 8'h32, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h0D, 8'h0A};
    exp_ow = '{8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h0D, 8'h0A,
               8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h33, 8'h0D, 8'h0A};
    exp_5  = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h35, 8'h0D, 8'h0A};

    for (int i = 0; i < 10; i++) check("model_char_pin", 32'(char_of(32'h12AB_CDEF, i)), 32'(exp_a[i]));

    #1 reset = 1'b0;
    #2 cmp_en = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_tx", 32'(tx4), 32'd1);
    check("reset_busy", 32'(busy4), 32'd0);
    check("reset_dropped", 32'(dropped4), 32'd0);
    reset = 1'b1;

    // Idle: dr stays 0, nothing may be sent.
    lowcnt = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (tx4 !== 1'b1 || busy4 !== 1'b0) lowcnt++;
    end
    check("idle_activity_cycles", 32'(lowcnt), 32'd0);
    check("idle_dropped", 32'(dropped4), 32'd0);

    // Single frame.
    dr4 = 32'h12AB_CDEF;
    check("pre_start_tx", 32'(tx4), 32'd1);
    busycnt = 0;
    fork
      decode4(10);
      begin
        @(negedge clk);
        check("start_one_cycle_later", 32'(tx4), 32'd0);
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          @(negedge clk);
          if (busy4 === 1'b1) busycnt++;
          else if (busycnt > 0) break;
        end
      end
    join
    for (int i = 0; i < 10; i++) check("single_frame_byte", 32'(dec_buf[i]), 32'(exp_a[i]));
    check("busy_length", 32'(busycnt), 32'd400);
    wait_idle(1000);

    // Overwrite: three values while one frame is in flight.
    @(negedge clk);
    dr4 = 32'hFFFF_FFFF;
    lowcnt = 0;
    fork
      decode4(20);
      begin
        for (int i = 0; i < 790; i++) begin
          @(negedge clk);
          if (busy4 !== 1'b1) lowcnt++;
        end
      end
      begin
        repeat (10) @(negedge clk);
        dr4 = 32'd1;
        @(negedge clk);
        dr4 = 32'd2;
        @(negedge clk);
        dr4 = 32'd3;
        @(negedge clk);
        check("overwrite_dropped", 32'(dropped4), 32'd2);
      end
    join
    for (int i = 0; i < 20; i++) check("overwrite_byte", 32'(dec_buf[i]), 32'(exp_ow[i]));
    check("busy_gap_cycles", 32'(lowcnt), 32'd0);
    wait_idle(1000);

    // Reset during DATA of character 3.
    @(negedge clk);
    dr4 = 32'h1234_5678;
    repeat (130) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_reset_tx", 32'(tx4), 32'd1);
    check("async_reset_busy", 32'(busy4), 32'd0);
    check("async_reset_dropped", 32'(dropped4), 32'd0);
    dr4 = 32'h5;
    @(negedge clk);
    reset = 1'b1;
    decode4(10);
    for (int i = 0; i < 10; i++) check("post_reset_byte", 32'(dec_buf[i]), 32'(exp_5[i]));
    wait_idle(1000);

    // Saturation of the drop counter.
    @(negedge clk);
    dr4 = 32'h77;
    for (int i = 0; i <= 300; i++) begin
      @(negedge clk);
      dr4 = 32'h1000 + 32'(i);
    end
    @(negedge clk);
    check("dropped_saturated", 32'(dropped4), 32'd255);
    wait_idle(1500);
    check("dropped_holds", 32'(dropped4), 32'd255);

    // Bit timing with five clocks per bit.
    @(negedge clk);
    dr5 = 32'hA;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      check("tx5_waveform", 32'(tx5), 32'(bitf(32'hA, k, C5)));
      check("busy5_in_frame", 32'(busy5), 32'd1);
    end
    @(negedge clk);
    check("busy5_after", 32'(busy5), 32'd0);
    check("tx5_after", 32'(tx5), 32'd1);
    check("dropped5", 32'(dropped5), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/osecpu_dr_uart_tx.md
Name: osecpu_dr_uart_tx

Overview:
- Debug-output stage directly downstream of the OSECPU core. It consumes the 32-bit debug register `dr` that the core updates on CPDR.
- On every change of `dr` it transmits the new value over an 8N1 UART line: 8 uppercase ASCII hex digits, MSB nibble first, followed by CR LF.
- Holds one pending value while a frame is in flight and counts values lost to overwrite.
- Sits at board top level between the `dr` output of the OSECPU top and the FPGA TX pin.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal minimum 2; counter width = $clog2(CLKS_PER_BIT).

Ports:
- clk  input  1  system clock, shared with the CPU core.
- reset  input  1  asynchronous, active-low reset; all state clears while low.
- dr  input  32  CPU debug register value, sampled every clk.
- tx  output  1  UART serial line; idle high.
- busy  output  1  high while a frame is being transmitted (state != IDLE).
- dropped  output  8  count of pending values overwritten before transmission; saturates at 255.

Behaviour:
- Reset (reset=0, async):
  - tx=1, busy=0, dropped=0.
  - shadow=0, pending_valid=0, pending=0.
  - state=IDLE, bit counter=0, char index=0.
  - Reset mid-frame aborts the frame immediately; tx returns to 1 without waiting for a clock edge.
- Change detection: at each posedge, if dr != shadow then shadow<=dr and a capture event occurs. dr==0 after reset is not a change and sends nothing.
- Capture event when state==IDLE:
  - frame register<=dr, char index<=0, state<=START.
  - tx is registered low at that same edge, so the start bit begins 1 cycle after dr changes.
- Capture event when state!=IDLE:
  - pending<=dr.
  - If pending_valid was already 1, dropped<=dropped+1 (saturating at 255).
  - pending_valid<=1. The latest value wins.
- FSM states: IDLE, START, DATA, STOP.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then:
    - If char index<9: char index+1, go to START with no idle gap.
    - Else (frame end): if pending_valid, frame<=pending, pending_valid<=0, char index<=0, go to START; otherwise go to IDLE.
- A capture event in the same cycle as frame end goes to pending; the pending value, including that new one, is sent next.
- Character mapping:
  - index 0..7 selects nibble frame[31-4i -: 4]; 0-9 map to 0x30-0x39, A-F map to 0x41-0x46.
  - index 8 = 0x0D, index 9 = 0x0A.
- Frame length: 10 chars × 10 bits × CLKS_PER_BIT = 100×CLKS_PER_BIT cycles.
- busy is registered: high from the start-bit edge through the last stop-bit cycle. Back-to-back frames keep it high continuously.
- Bit timing: each bit lasts exactly CLKS_PER_BIT clk cycles, with no jitter across char boundaries.
- Changes of dr while reset is low are ignored. After release, the first edge compares against shadow=0.

Test Plan:
- Idle: reset pulse, dr held 0 for 2000 cycles -> tx constant 1, busy 0, dropped 0.
- Single frame (CLKS_PER_BIT=4): dr=0x12ABCDEF -> decoded bytes 0x31 0x32 0x41 0x42 0x43 0x44 0x45 0x46 0x0D 0x0A. busy high exactly 400 cycles. Start-bit low begins 1 cycle after the dr change.
- Overwrite/queue: during a frame for 0xFFFFFFFF, set dr=1, 2, 3 in separate cycles -> dropped=2. The next frame starts immediately after LF with no idle gap and decodes as "00000003\r\n". busy never drops between the two frames.
- Bit timing: CLKS_PER_BIT=5, dr=0xA -> every bit period measured as exactly 5 cycles, including char-to-char transitions. Stop bit = 1. LSB first within each byte.
- Reset mid-frame: assert reset during the DATA state of char 3 -> tx=1 and busy=0 asynchronously, dropped=0. Release with dr held 0x5 -> fresh frame "00000005\r\n".
- Saturation: hold the core busy while toggling dr through 300 distinct values after pending is set -> dropped=255 and does not wrap.
